// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Define MULDIV_FAST_ZERO_EN to skip iteration for zero multiply, divide-by-zero and signed overflow.

module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wr_reg
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  funct_q, funct_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] opB_q, opB_d;
  logic [31:0] aRaw_q, aRaw_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        divZero_q, divZero_d;
  logic        ovf_q, ovf_d;
  logic        mulZero_q, mulZero_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  wrReg_q, wrReg_d;

  logic        signA, signB, aNeg, bNeg, inNeg;
  logic [31:0] aMag, bMag;
  logic        inDivZero, inOvf, inMulZero;

  // Operand signedness per funct3: only MULH/MULHSU/DIV/REM treat rs1 as signed.
  assign signA     = funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]);
  assign signB     = funct3[2] ? ~funct3[0] : (~funct3[1] & funct3[0]);
  assign aNeg      = signA & op_a[31];
  assign bNeg      = signB & op_b[31];
  assign aMag      = aNeg ? (~op_a + 32'd1) : op_a;
  assign bMag      = bNeg ? (~op_b + 32'd1) : op_b;
  assign inNeg     = (funct3[2] & funct3[1]) ? aNeg : (aNeg ^ bNeg);
  assign inDivZero = (op_b == 32'd0);
  assign inOvf     = funct3[2] & signA & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
  assign inMulZero = (op_a == 32'd0) || (op_b == 32'd0);

`ifdef MULDIV_FAST_ZERO_EN
  logic fastSpecial;
  assign fastSpecial = funct3[2] ? (inDivZero | inOvf) : inMulZero;
`endif

  // acc holds {high, low}: multiplier/product for multiply, {remainder, quotient} for divide.
  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic        divGe;
  logic [31:0] divRem;

  assign mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opB_q} : 33'd0);
  assign divShift = acc_q[63:31];
  assign divGe    = (divShift >= {1'b0, opB_q});
  assign divRem   = divGe ? (divShift[31:0] - opB_q) : divShift[31:0];

  logic [63:0] prodSigned;
  logic [31:0] quotSigned, remSigned, fixResult;

  assign prodSigned = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign quotSigned = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign remSigned  = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    fixResult = 32'd0;
    if (!funct_q[2]) begin
      if (!mulZero_q)
        fixResult = (funct_q[1:0] == 2'b00) ? prodSigned[31:0] : prodSigned[63:32];
    end else if (divZero_q) begin
      fixResult = funct_q[1] ? aRaw_q : 32'hFFFF_FFFF;
    end else if (ovf_q) begin
      fixResult = funct_q[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      fixResult = funct_q[1] ? remSigned : quotSigned;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
`ifdef MULDIV_FAST_ZERO_EN
        state_d = fastSpecial ? FIX : CALC;
`else
        state_d = CALC;
`endif
      end
      CALC:    if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    result = result_q;
    wr_reg = wrReg_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    funct_d   = funct_q;
    rd_d      = rd_q;
    opB_d     = opB_q;
    aRaw_d    = aRaw_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
    mulZero_d = mulZero_q;
    result_d  = result_q;
    wrReg_d   = wrReg_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d     = 5'd0;
        funct_d   = funct3;
        rd_d      = rd_in;
        opB_d     = bMag;
        aRaw_d    = op_a;
        acc_d     = {32'd0, aMag};
        neg_d     = inNeg;
        divZero_d = inDivZero;
        ovf_d     = inOvf;
        mulZero_d = inMulZero;
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        acc_d = funct_q[2] ? {divRem, acc_q[30:0], divGe} : {mulSum, acc_q[31:1]};
      end
      FIX: begin
        result_d = fixResult;
        wrReg_d  = rd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 5'd0;
      funct_q   <= 3'd0;
      rd_q      <= 5'd0;
      opB_q     <= 32'd0;
      aRaw_q    <= 32'd0;
      acc_q     <= 64'd0;
      neg_q     <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
      mulZero_q <= 1'b0;
      result_q  <= 32'd0;
      wrReg_q   <= 5'd0;
    end else begin
      cnt_q     <= cnt_d;
      funct_q   <= funct_d;
      rd_q      <= rd_d;
      opB_q     <= opB_d;
      aRaw_q    <= aRaw_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
      mulZero_q <= mulZero_d;
      result_q  <= result_d;
      wrReg_q   <= wrReg_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic RV32M reference model.
// Latency is counted in edges with the accepting edge as edge 1.

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  wr_reg;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .wr_reg (wr_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, sp;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    up = {32'd0, a} * {32'd0, b};
    case (f)
      3'b000: return up[31:0];
      3'b001: begin sp = sa * sb; return sp[63:32]; end
      3'b010: begin sp = sa * ub; return sp[63:32]; end
      3'b011: return up[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int expLat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = f[2] ? (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                   : (a == 0 || b == 0);
`ifdef MULDIV_FAST_ZERO_EN
    if (special) return 2;
`else
    if (special) return 34;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic scrambleInputs();
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom);
  endtask

  task automatic waitDone(input int first, output logic [31:0] res, output logic [4:0] wr, output int lat);
    lat = 0;
    res = '0;
    wr  = '0;
    for (int n = first; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        res = result;
        wr  = wr_reg;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(posedge clk); #1;
    start = 1'b0;
    scrambleInputs();
  endtask

  task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       output logic [31:0] res, output logic [4:0] wr, output int lat, output logic bsy);
    applyStimulus(f, a, b, rd);
    bsy = busy;
    waitDone(2, res, wr, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    scrambleInputs();
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
    if (result !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_result got %h want 0", result); end
    if (wr_reg !== 5'd0)  begin miscompares++; $display("[TB] FAIL reset_wr_reg got %0d want 0", wr_reg); end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_over_start busy got %b want 0", busy); end
  endtask

  task automatic test_directed(input string tag, input vec_t v[$]);
    logic [31:0] res;
    logic [4:0]  wr, rd;
    int          lat;
    logic        bsy;
    foreach (v[i]) begin
      rd = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
      runOp(v[i].f, v[i].a, v[i].b, rd, res, wr, lat, bsy);
      vectors += 4;
      if (res !== v[i].e) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d] result f=%b a=%h b=%h got %h want %h", tag, i, v[i].f, v[i].a, v[i].b, res, v[i].e);
      end
      if (wr !== rd) begin miscompares++; $display("[TB] FAIL %s[%0d] wr_reg got %0d want %0d", tag, i, wr, rd); end
      if (lat != expLat(v[i].f, v[i].a, v[i].b)) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d] latency got %0d want %0d", tag, i, lat, expLat(v[i].f, v[i].a, v[i].b));
      end
      if (bsy !== 1'b1) begin miscompares++; $display("[TB] FAIL %s[%0d] busy_after_accept got %b want 1", tag, i, bsy); end
      @(posedge clk); #1;
      vectors += 2;
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL %s[%0d] done_width got %b want 0", tag, i, done); end
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL %s[%0d] busy_after_done got %b want 0", tag, i, busy); end
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    v.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    v.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    v.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    test_directed("mul", v);
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    v.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    v.push_back('{3'b101, 32'd100, 32'd7, 32'd14});
    v.push_back('{3'b111, 32'd100, 32'd7, 32'd2});
    test_directed("div", v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF});
    v.push_back('{3'b111, 32'd5, 32'd0, 32'd5});
    v.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    v.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    v.push_back('{3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF});
    v.push_back('{3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB});
    v.push_back('{3'b001, 32'd0, 32'h1234_5678, 32'd0});
    test_directed("special", v);
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res;
    logic [4:0]  rd, wr;
    int          lat;
    logic        bsy;
    for (int i = 0; i < 24; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      rd = 5'($urandom);
      runOp(f, a, b, rd, res, wr, lat, bsy);
      vectors += 3;
      if (res !== refModel(f, a, b)) begin
        miscompares++;
        $display("[TB] FAIL rand[%0d] result f=%b a=%h b=%h got %h want %h", i, f, a, b, res, refModel(f, a, b));
      end
      if (wr !== rd) begin miscompares++; $display("[TB] FAIL rand[%0d] wr_reg got %0d want %0d", i, wr, rd); end
      if (lat != expLat(f, a, b)) begin
        miscompares++;
        $display("[TB] FAIL rand[%0d] latency got %0d want %0d", i, lat, expLat(f, a, b));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res;
    logic [4:0]  wr;
    int          lat, extra;
    applyStimulus(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    rd_in  = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ignore busy_at_5 got %b want 1", busy); end
    waitDone(6, res, wr, lat);
    vectors += 3;
    if (res !== 32'hFFFF_FFF2) begin miscompares++; $display("[TB] FAIL ignore result got %h want fffffff2", res); end
    if (wr !== 5'd9) begin miscompares++; $display("[TB] FAIL ignore wr_reg got %0d want 9", wr); end
    if (lat != 34) begin miscompares++; $display("[TB] FAIL ignore latency got %0d want 34", lat); end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("[TB] FAIL ignore queued_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_abort();
    int extra;
    applyStimulus(3'b100, 32'd123456, 32'd11, 5'd17);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors += 4;
    if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL abort busy got %b want 0", busy); end
    if (done !== 1'b0)    begin miscompares++; $display("[TB] FAIL abort done got %b want 0", done); end
    if (result !== 32'd0) begin miscompares++; $display("[TB] FAIL abort result got %h want 0", result); end
    if (wr_reg !== 5'd0)  begin miscompares++; $display("[TB] FAIL abort wr_reg got %0d want 0", wr_reg); end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("[TB] FAIL abort late_done got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, a2, b2;
    logic [4:0]  wr;
    int          lat;
    a2 = $urandom;
    b2 = $urandom_range(1, 1000);
    applyStimulus(3'b011, $urandom, $urandom, 5'd3);
    waitDone(2, res, wr, lat);
    start  = 1'b1;
    funct3 = 3'b111;
    op_a   = a2;
    op_b   = b2;
    rd_in  = 5'd30;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b start_in_done busy got %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    scrambleInputs();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b accept_in_idle busy got %b want 1", busy); end
    waitDone(2, res, wr, lat);
    vectors += 3;
    if (res !== refModel(3'b111, a2, b2)) begin
      miscompares++;
      $display("[TB] FAIL b2b result got %h want %h", res, refModel(3'b111, a2, b2));
    end
    if (wr !== 5'd30) begin miscompares++; $display("[TB] FAIL b2b wr_reg got %0d want 30", wr); end
    if (lat != 34) begin miscompares++; $display("[TB] FAIL b2b latency got %0d want 34", lat); end
    @(posedge clk); #1;
  endtask

  task automatic checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    checkOutput();
    $finish;
  end

endmodule
